// File: rtl/maple_pkg.sv
// Shared encodings for the Maple bus transmit scheduler: one-hot FSM states,
// header byte indices and header field positions.
package maple_pkg;

  typedef enum logic [6:0] {
    StIdle    = 7'b000_0001,
    StStart   = 7'b000_0010,
    StHeader  = 7'b000_0100,
    StPayload = 7'b000_1000,
    StCrc     = 7'b001_0000,
    StDrain   = 7'b010_0000,
    StDone    = 7'b100_0000
  } state_e;

  // Wire order of the header bytes
  localparam logic [1:0] HdrIdxLen = 2'd0;
  localparam logic [1:0] HdrIdxSrc = 2'd1;
  localparam logic [1:0] HdrIdxDst = 2'd2;
  localparam logic [1:0] HdrIdxCmd = 2'd3;

  localparam int unsigned HdrLenLsb = 0;
  localparam int unsigned HdrSrcLsb = 8;
  localparam int unsigned HdrDstLsb = 16;
  localparam int unsigned HdrCmdLsb = 24;

  function automatic logic [7:0] hdr_byte(input logic [31:0] hdr, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      HdrIdxLen: b = hdr[HdrLenLsb +: 8];
      HdrIdxSrc: b = hdr[HdrSrcLsb +: 8];
      HdrIdxDst: b = hdr[HdrDstLsb +: 8];
      default:   b = hdr[HdrCmdLsb +: 8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/maple_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer moves past the winner only when the
// grant is accepted.
module maple_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic ptr_q;

  assign gnt_valid_o = |req_i;
  // With a single requester it wins outright; the pointer only breaks ties
  assign gnt_id_o    = (req_i == 2'b11) ? ptr_q : req_i[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (accept_i) begin
      ptr_q <= ~gnt_id_o;
    end
  end

endmodule

// File: rtl/maple_tx_scheduler.sv
// Maple bus transmit scheduler: arbitrates two frame requesters, then streams
// header, payload and XOR checksum bytes over the transmitter handshake.
module maple_tx_scheduler
  import maple_pkg::*;
#(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [63:0] req_hdr,
  output logic [1:0]  req_ack,
  input  logic [15:0] pl_data,
  input  logic [1:0]  pl_valid,
  output logic [1:0]  pl_ready,
  output logic        tx_enable,
  output logic [7:0]  tx_data,
  input  logic        tx_next,
  input  logic        tx_busy,
  output logic        busy,
  output logic        grant_id,
  output logic        done,
  output logic        underrun
);

  state_e           state_q;
  logic             gid_q;
  logic [31:0]      hdr_q;
  logic [1:0]       hidx_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [7:0]       txd_q;
  logic [7:0]       csum_q;
  logic [7:0]       hold_q;
  logic             hold_v_q;
  logic             und_q;

  logic             gnt_valid;
  logic             gnt_id;
  logic             grant;
  logic [31:0]      sel_hdr;
  logic [CNT_W-1:0] pl_len;
  logic             len_zero;
  logic             fetch_state;
  logic             consume;
  logic             pl_room;
  logic             pl_fire;
  logic [7:0]       pl_byte;
  logic [7:0]       cur_byte;

  maple_rr_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_valid),
    .accept_i    (grant),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  assign grant    = (state_q == StIdle) && gnt_valid;
  assign sel_hdr  = gnt_id ? req_hdr[63:32] : req_hdr[31:0];
  assign pl_len   = CNT_W'({hdr_q[HdrLenLsb +: LEN_W], 2'b00});
  assign len_zero = (hdr_q[HdrLenLsb +: LEN_W] == '0);

  // Payload may be prefetched into the holding register from START onwards
  assign fetch_state = (state_q == StStart) || (state_q == StHeader) || (state_q == StPayload);
  assign consume     = (state_q == StPayload) && tx_next;
  assign pl_room     = fetch_state && (acc_cnt_q != pl_len) && (!hold_v_q || consume);
  assign pl_fire     = pl_room && pl_valid[gid_q];
  assign pl_byte     = gid_q ? pl_data[15:8] : pl_data[7:0];
  assign cur_byte    = hold_v_q ? hold_q : 8'h00;

  always_comb begin
    req_ack = 2'b00;
    if (grant && !reset) begin
      req_ack[gnt_id] = 1'b1;
    end
    pl_ready = 2'b00;
    pl_ready[gid_q] = pl_room;
  end

  assign tx_enable = (state_q == StStart) || (state_q == StHeader) ||
                     (state_q == StPayload) || (state_q == StCrc);
  assign tx_data   = (state_q == StPayload) ? cur_byte : txd_q;
  assign busy      = (state_q != StIdle);
  assign grant_id  = gid_q;
  assign done      = (state_q == StDone);
  assign underrun  = done && und_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      gid_q     <= 1'b0;
      hdr_q     <= '0;
      hidx_q    <= HdrIdxLen;
      tx_cnt_q  <= '0;
      acc_cnt_q <= '0;
      txd_q     <= '0;
      csum_q    <= '0;
      hold_q    <= '0;
      hold_v_q  <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            state_q  <= StStart;
            gid_q    <= gnt_id;
            hdr_q    <= sel_hdr;
            txd_q    <= hdr_byte(sel_hdr, HdrIdxLen);
            hidx_q   <= HdrIdxLen;
            csum_q   <= '0;
            tx_cnt_q <= '0;
            und_q    <= 1'b0;
          end
        end
        StStart: begin
          if (tx_busy) state_q <= StHeader;
        end
        StHeader: begin
          if (tx_next) begin
            csum_q <= csum_q ^ txd_q;
            if (hidx_q == HdrIdxCmd) begin
              if (len_zero) begin
                state_q <= StCrc;
                txd_q   <= csum_q ^ txd_q;
              end else begin
                state_q <= StPayload;
              end
            end else begin
              hidx_q <= hidx_q + 2'd1;
              txd_q  <= hdr_byte(hdr_q, hidx_q + 2'd1);
            end
          end
        end
        StPayload: begin
          if (tx_next) begin
            csum_q   <= csum_q ^ cur_byte;
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            if (!hold_v_q) und_q <= 1'b1;
            if (tx_cnt_q == pl_len - CNT_W'(1)) begin
              state_q <= StCrc;
              txd_q   <= csum_q ^ cur_byte;
            end
          end
        end
        StCrc: begin
          if (tx_next) begin
            state_q <= StDrain;
            txd_q   <= '0;
          end
        end
        StDrain: begin
          if (!tx_busy) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (grant) begin
        hold_v_q  <= 1'b0;
        acc_cnt_q <= '0;
      end else if (pl_fire) begin
        hold_v_q  <= 1'b1;
        hold_q    <= pl_byte;
        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      end else if (consume) begin
        hold_v_q <= 1'b0;
      end
    end
  end

endmodule
